program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 20 ++
 rtl/program_loader_byte_packer.sv | 41 ++++
 rtl/program_loader.sv | 93 +++++++++
 tb/tb_program_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encoding,
// halt opcode and default geometry of the program memory.
package program_loader_pkg;

  localparam int NBITS_O_DEF = 11;
  localparam int NBITS_D_DEF = 16;
  localparam int CELDAS_DEF  = 512;

  localparam logic [4:0] HALT_OPCODE = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX_LO = 3'd1,
    ST_RX_HI = 3'd2,
    ST_WRITE = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Collects a low byte and a high byte from the UART into one instruction
// word and flags the cycle right after the high byte arrives.
module byte_packer
  import program_loader_pkg::*;
#(
  parameter int NBITS_D = NBITS_D_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               clear,
  input  logic               capture_lo,
  input  logic               capture_hi,
  input  logic [7:0]         rx_data,
  output logic [NBITS_D-1:0] word,
  output logic               word_valid
);

  logic [7:0] lo_q;
  logic [7:0] hi_q;
  logic       valid_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      valid_q <= 1'b0;
    end else if (clear) begin
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      if (capture_lo) lo_q <= rx_data;
      if (capture_hi) hi_q <= rx_data;
      valid_q <= capture_hi;
    end
  end

  assign word       = NBITS_D'({hi_q, lo_q});
  assign word_valid = valid_q;

endmodule

// File: rtl/program_loader.sv
// Loads a program received as byte pairs over UART into program memory,
// then releases the CPU from reset until it reports a halt.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int NBITS_O = NBITS_O_DEF,
  parameter int NBITS_D = NBITS_D_DEF,
  parameter int CELDAS  = CELDAS_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_cpu_halt,
  output logic               o_mem_we,
  output logic [NBITS_O-1:0] o_mem_addr,
  output logic [NBITS_D-1:0] o_mem_data,
  output logic               o_cpu_enable,
  output logic               o_cpu_reset,
  output logic               o_done,
  output logic [NBITS_O-1:0] o_word_count
);

  localparam logic [NBITS_O-1:0] LAST_ADDR = NBITS_O'(CELDAS - 1);

  state_t             state, state_next;
  logic [NBITS_O-1:0] counter;
  logic [NBITS_O-1:0] addr_hold;
  logic [NBITS_D-1:0] data_hold;
  logic [NBITS_D-1:0] word;
  logic               word_valid;
  logic               start_load;
  logic               wr_active;
  logic               last_word;

  assign start_load = i_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign wr_active  = (state == ST_WRITE) && word_valid;
  assign last_word  = (word[NBITS_D-1 -: 5] == HALT_OPCODE) || (counter == LAST_ADDR);

  byte_packer #(.NBITS_D(NBITS_D)) u_packer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .clear      (start_load),
    .capture_lo ((state == ST_RX_LO) && i_rx_done),
    .capture_hi ((state == ST_RX_HI) && i_rx_done),
    .rx_data    (i_rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (i_start) state_next = ST_RX_LO;
      ST_RX_LO: if (i_rx_done) state_next = ST_RX_HI;
      ST_RX_HI: if (i_rx_done) state_next = ST_WRITE;
      ST_WRITE: state_next = last_word ? ST_RUN : ST_RX_LO;
      ST_RUN:   if (i_cpu_halt) state_next = ST_DONE;
      ST_DONE:  if (i_start) state_next = ST_RX_LO;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The final cell saturates the counter instead of stepping past the memory.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      counter   <= '0;
      addr_hold <= '0;
      data_hold <= '0;
    end else if (start_load) begin
      counter <= '0;
    end else if (wr_active) begin
      addr_hold <= counter;
      data_hold <= word;
      if (counter != LAST_ADDR) counter <= counter + 1'b1;
    end
  end

  assign o_mem_we     = wr_active;
  assign o_mem_addr   = wr_active ? counter : addr_hold;
  assign o_mem_data   = wr_active ? word : data_hold;
  assign o_cpu_enable = (state == ST_RUN);
  assign o_cpu_reset  = (state != ST_RUN);
  assign o_done       = (state == ST_DONE);
  assign o_word_count = counter;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a scoreboard queue holds the
// expected memory writes, a monitor pops and compares each one.
module tb_program_loader;

  localparam int NBITS_O = 11;
  localparam int NBITS_D = 16;
  localparam int CELDAS  = 512;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic               i_start;
  logic [7:0]         i_rx_data;
  logic               i_rx_done;
  logic               i_cpu_halt;
  logic               o_mem_we;
  logic [NBITS_O-1:0] o_mem_addr;
  logic [NBITS_D-1:0] o_mem_data;
  logic               o_cpu_enable;
  logic               o_cpu_reset;
  logic               o_done;
  logic [NBITS_O-1:0] o_word_count;

  int compared   = 0;
  int mismatched = 0;

  logic [NBITS_O+NBITS_D-1:0] exp_q[$];

  program_loader #(.NBITS_O(NBITS_O), .NBITS_D(NBITS_D), .CELDAS(CELDAS)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_cpu_halt   (i_cpu_halt),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_cpu_enable (o_cpu_enable),
    .o_cpu_reset  (o_cpu_reset),
    .o_done       (o_done),
    .o_word_count (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  // Every write strobe must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (i_reset === 1'b1 && o_mem_we === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write", o_mem_addr, o_mem_data);
      end else begin
        logic [NBITS_O+NBITS_D-1:0] exp;
        exp = exp_q.pop_front();
        if ({o_mem_addr, o_mem_data} !== exp) begin
          mismatched++;
          $display("[TB] FAIL mem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   o_mem_addr, o_mem_data, exp[NBITS_O+NBITS_D-1:NBITS_D], exp[NBITS_D-1:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_write(input int addr, input logic [15:0] data);
    exp_q.push_back({NBITS_O'(addr), data});
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] lo, input logic [7:0] hi);
    send_byte(lo);
    send_byte(hi);
    @(negedge i_clk);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic pulse_halt();
    i_cpu_halt = 1'b1;
    @(negedge i_clk);
    i_cpu_halt = 1'b0;
  endtask

  task automatic check_run(input string name, input int count);
    compared++;
    if (o_cpu_enable !== 1'b1 || o_cpu_reset !== 1'b0 || o_done !== 1'b0 || o_word_count !== NBITS_O'(count)) begin
      mismatched++;
      $display("[TB] FAIL %s: got en=%b rst=%b done=%b count=%0d, expected en=1 rst=0 done=0 count=%0d",
               name, o_cpu_enable, o_cpu_reset, o_done, o_word_count, count);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    #3;
    compared++;
    if (o_mem_we !== 1'b0 || o_mem_addr !== '0 || o_mem_data !== '0 || o_cpu_enable !== 1'b0 ||
        o_cpu_reset !== 1'b1 || o_done !== 1'b0 || o_word_count !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got we=%b addr=%0d data=%h en=%b rst=%b done=%b count=%0d, expected 0/0/0000/0/1/0/0",
               o_mem_we, o_mem_addr, o_mem_data, o_cpu_enable, o_cpu_reset, o_done, o_word_count);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_basic_load();
    pulse_start();
    push_write(0, 16'h1001);
    send_word(8'h01, 8'h10);
    push_write(1, 16'h2802);
    send_word(8'h02, 8'h28);
    push_write(2, 16'h0000);
    send_word(8'h00, 8'h00);
    check_run("basic_run", 3);
  endtask

  task automatic test_halt_done();
    pulse_halt();
    compared++;
    if (o_done !== 1'b1 || o_cpu_reset !== 1'b1 || o_cpu_enable !== 1'b0 || o_word_count !== NBITS_O'(3)) begin
      mismatched++;
      $display("[TB] FAIL halt_done: got done=%b rst=%b en=%b count=%0d, expected 1/1/0/3",
               o_done, o_cpu_reset, o_cpu_enable, o_word_count);
    end
    pulse_start();
    compared++;
    if (o_word_count !== '0 || o_done !== 1'b0 || o_cpu_reset !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL restart: got count=%0d done=%b rst=%b, expected 0/0/1", o_word_count, o_done, o_cpu_reset);
    end
  endtask

  task automatic test_reset_midload();
    push_write(0, 16'h1001);
    send_word(8'h01, 8'h10);
    send_byte(8'h02);
    #2;
    i_reset = 1'b0;
    #1;
    compared++;
    if (o_mem_we !== 1'b0 || o_mem_addr !== '0 || o_mem_data !== '0 || o_cpu_enable !== 1'b0 ||
        o_cpu_reset !== 1'b1 || o_done !== 1'b0 || o_word_count !== '0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got we=%b addr=%0d data=%h en=%b rst=%b done=%b count=%0d, expected 0/0/0000/0/1/0/0",
               o_mem_we, o_mem_addr, o_mem_data, o_cpu_enable, o_cpu_reset, o_done, o_word_count);
    end
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    pulse_start();
    push_write(0, 16'h1001);
    send_word(8'h01, 8'h10);
    push_write(1, 16'h0000);
    send_word(8'h00, 8'h00);
    check_run("reload_run", 2);
    pulse_halt();
  endtask

  task automatic test_ignored_inputs();
    pulse_start();
    push_write(0, 16'h1001);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'hAA);
    send_byte(8'h02);
    pulse_start();
    compared++;
    if (o_word_count !== NBITS_O'(1) || o_mem_we !== 1'b0 || o_cpu_reset !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL start_in_rx_hi: got count=%0d we=%b rst=%b, expected 1/0/1", o_word_count, o_mem_we, o_cpu_reset);
    end
    push_write(1, 16'h2802);
    send_byte(8'h28);
    @(negedge i_clk);
    push_write(2, 16'h0000);
    send_word(8'h00, 8'h00);
    check_run("ignore_run", 3);
    pulse_halt();
  endtask

  task automatic test_full_load();
    pulse_start();
    for (int i = 0; i < CELDAS; i++) begin
      push_write(i, 16'h0801);
      send_word(8'h01, 8'h08);
    end
    check_run("full_run", CELDAS - 1);
    repeat (3) @(negedge i_clk);
    check_run("full_hold", CELDAS - 1);
    pulse_halt();
  endtask

  initial begin
    i_reset    = 1'b0;
    i_start    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_done  = 1'b0;
    i_cpu_halt = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_basic_load();
    test_halt_done();
    test_reset_midload();
    test_ignored_inputs();
    test_full_load();
    repeat (2) @(negedge i_clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL missing_writes: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
